// File: rtl/sat_step_counter_if.sv
// -----------------------------------------------------------------------------
// sat_step_counter_if
// Groups the button inputs and counter outputs of sat_step_counter.
//   BTN_UP / BTN_DN : raw push-buttons, active-high, asynchronous to the clock
//   Q               : registered count, WIDTH bits
//   AT_MAX / AT_MIN : Q at the upper / lower saturation limit
//   STEP / SAT      : one-cycle pulses for a taken / blocked step
// master: the side that presses the buttons and observes the count.
// slave : the counter itself.
// -----------------------------------------------------------------------------
interface sat_step_counter_if #(
    parameter int WIDTH = 4
);
    logic             BTN_UP;
    logic             BTN_DN;
    logic [WIDTH-1:0] Q;
    logic             AT_MAX;
    logic             AT_MIN;
    logic             STEP;
    logic             SAT;

    modport master (
        output BTN_UP, BTN_DN,
        input  Q, AT_MAX, AT_MIN, STEP, SAT
    );

    modport slave (
        input  BTN_UP, BTN_DN,
        output Q, AT_MAX, AT_MIN, STEP, SAT
    );
endinterface

// File: rtl/sat_step_counter.sv
// -----------------------------------------------------------------------------
// sat_step_counter
// Up/down saturating counter driven by two raw push-buttons. Each button is
// synchronised (2 FFs), debounced, edge-detected and turned into one-cycle
// step requests, with auto-repeat while a single button stays held.
// Ports:
//   CLK     : system clock, rising edge
//   N_RESET : asynchronous active-low reset
//   bus     : sat_step_counter_if.slave (BTN_UP, BTN_DN in; Q, AT_MAX,
//             AT_MIN, STEP, SAT out)
// -----------------------------------------------------------------------------
module sat_step_counter #(
    parameter int               WIDTH         = 4,
    parameter int               DEBOUNCE      = 4,
    parameter int               REPEAT_DELAY  = 16,
    parameter int               REPEAT_PERIOD = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE   = {WIDTH{1'b0}}
) (
    input logic               CLK,
    input logic               N_RESET,
    sat_step_counter_if.slave bus
);

    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int TM_W = $clog2(REPEAT_DELAY);

    localparam logic [DB_W-1:0]  DB_ZERO   = {DB_W{1'b0}};
    localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1'b1);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE - 1);
    localparam logic [TM_W-1:0]  TM_ZERO   = {TM_W{1'b0}};
    localparam logic [TM_W-1:0]  TM_ONE    = TM_W'(1'b1);
    localparam logic [TM_W-1:0]  TM_FIRE   = TM_W'(REPEAT_DELAY - 1);
    localparam logic [TM_W-1:0]  TM_RELOAD = TM_W'(REPEAT_DELAY - REPEAT_PERIOD);
    localparam logic [WIDTH-1:0] Q_MAX     = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] Q_MIN     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] Q_ONE     = WIDTH'(1'b1);

    typedef enum logic [1:0] {
        ARM_IDLE = 2'b00,
        ARM_UP   = 2'b01,
        ARM_DN   = 2'b10
    } arm_e;

    // Returns {db_next, cnt_next}: db only follows s after DEBOUNCE
    // consecutive cycles of disagreement; any agreement clears the count.
    function automatic logic [DB_W:0] debounce_next(
        input logic            s,
        input logic            db,
        input logic [DB_W-1:0] cnt
    );
        logic [DB_W:0] r;
        if (s == db) begin
            r = {db, DB_ZERO};
        end else if (cnt == DB_LAST) begin
            r = {s, DB_ZERO};
        end else begin
            r = {db, cnt + DB_ONE};
        end
        return r;
    endfunction

    logic            up_meta_q, up_sync_q, dn_meta_q, dn_sync_q;
    logic [DB_W-1:0] up_cnt_q, up_cnt_d, dn_cnt_q, dn_cnt_d;
    logic            up_db_q, up_db_d, dn_db_q, dn_db_d;
    logic            up_db_dly_q, dn_db_dly_q;
    logic            press_up_s, press_dn_s;
    arm_e            arm_q, arm_d;
    logic [TM_W-1:0] tmr_q, tmr_d;
    logic            req_up_s, req_dn_s;
    logic [WIDTH-1:0] q_q, q_d;
    logic            step_q, step_d, sat_q, sat_d;
    logic            at_max_s, at_min_s;

    // Debounce next-state for both buttons.
    always_comb begin
        {up_db_d, up_cnt_d} = debounce_next(up_sync_q, up_db_q, up_cnt_q);
        {dn_db_d, dn_cnt_d} = debounce_next(dn_sync_q, dn_db_q, dn_cnt_q);
    end

    assign press_up_s = up_db_q & ~up_db_dly_q;
    assign press_dn_s = dn_db_q & ~dn_db_dly_q;

    // Synchroniser, debounce and edge-detect registers.
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            up_meta_q   <= 1'b0;
            up_sync_q   <= 1'b0;
            dn_meta_q   <= 1'b0;
            dn_sync_q   <= 1'b0;
            up_cnt_q    <= DB_ZERO;
            dn_cnt_q    <= DB_ZERO;
            up_db_q     <= 1'b0;
            dn_db_q     <= 1'b0;
            up_db_dly_q <= 1'b0;
            dn_db_dly_q <= 1'b0;
        end else begin
            up_meta_q   <= bus.BTN_UP;
            up_sync_q   <= up_meta_q;
            dn_meta_q   <= bus.BTN_DN;
            dn_sync_q   <= dn_meta_q;
            up_cnt_q    <= up_cnt_d;
            dn_cnt_q    <= dn_cnt_d;
            up_db_q     <= up_db_d;
            dn_db_q     <= dn_db_d;
            up_db_dly_q <= up_db_q;
            dn_db_dly_q <= dn_db_q;
        end
    end

    // Step request generation: initial press, both-held lockout, auto-repeat.
    always_comb begin
        arm_d    = arm_q;
        tmr_d    = tmr_q;
        req_up_s = 1'b0;
        req_dn_s = 1'b0;
        if (press_up_s && !dn_db_q) begin
            req_up_s = 1'b1;
            arm_d    = ARM_UP;
            tmr_d    = TM_ZERO;
        end else if (press_dn_s && !up_db_q) begin
            req_dn_s = 1'b1;
            arm_d    = ARM_DN;
            tmr_d    = TM_ZERO;
        end else if (up_db_q && dn_db_q) begin
            // Both held: a fresh press of the other button is swallowed and
            // repeat stays off until a new clean rising edge.
            arm_d = ARM_IDLE;
            tmr_d = TM_ZERO;
        end else begin
            case (arm_q)
                ARM_UP: begin
                    if (up_db_q) begin
                        if (tmr_q == TM_FIRE) begin
                            req_up_s = 1'b1;
                            tmr_d    = TM_RELOAD;
                        end else begin
                            tmr_d = tmr_q + TM_ONE;
                        end
                    end else begin
                        arm_d = ARM_IDLE;
                        tmr_d = TM_ZERO;
                    end
                end
                ARM_DN: begin
                    if (dn_db_q) begin
                        if (tmr_q == TM_FIRE) begin
                            req_dn_s = 1'b1;
                            tmr_d    = TM_RELOAD;
                        end else begin
                            tmr_d = tmr_q + TM_ONE;
                        end
                    end else begin
                        arm_d = ARM_IDLE;
                        tmr_d = TM_ZERO;
                    end
                end
                default: begin
                    arm_d = ARM_IDLE;
                    tmr_d = TM_ZERO;
                end
            endcase
        end
    end

    // Repeat arm state and timer.
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            arm_q <= ARM_IDLE;
            tmr_q <= TM_ZERO;
        end else begin
            arm_q <= arm_d;
            tmr_q <= tmr_d;
        end
    end

    assign at_max_s = (q_q == Q_MAX);
    assign at_min_s = (q_q == Q_MIN);

    // Saturating update: the limit is tested before the add/subtract.
    always_comb begin
        q_d    = q_q;
        step_d = 1'b0;
        sat_d  = 1'b0;
        if (req_up_s) begin
            if (!at_max_s) begin
                q_d    = q_q + Q_ONE;
                step_d = 1'b1;
            end else begin
                sat_d = 1'b1;
            end
        end else if (req_dn_s) begin
            if (!at_min_s) begin
                q_d    = q_q - Q_ONE;
                step_d = 1'b1;
            end else begin
                sat_d = 1'b1;
            end
        end else begin
            q_d = q_q;
        end
    end

    // Count and pulse registers.
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            q_q    <= RESET_VALUE;
            step_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            step_q <= step_d;
            sat_q  <= sat_d;
        end
    end

    assign bus.Q      = q_q;
    assign bus.AT_MAX = at_max_s;
    assign bus.AT_MIN = at_min_s;
    assign bus.STEP   = step_q;
    assign bus.SAT    = sat_q;

endmodule

// File: tb/tb_sat_step_counter.sv
module tb_sat_step_counter;

    logic CLK     = 1'b0;
    logic N_RESET = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    sat_step_counter_if #(.WIDTH(4)) bus ();

    sat_step_counter #(
        .WIDTH(4), .DEBOUNCE(4), .REPEAT_DELAY(16), .REPEAT_PERIOD(8),
        .RESET_VALUE(4'd0)
    ) dut (
        .CLK(CLK),
        .N_RESET(N_RESET),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    // One active edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        bus.BTN_UP = 1'b1;
        bus.BTN_DN = 1'b1;
        #1 N_RESET = 1'b0;
        tick();
        tick();
        tests_run++;
        if (bus.Q !== 4'd0 || bus.AT_MIN !== 1'b1 || bus.AT_MAX !== 1'b0 ||
            bus.STEP !== 1'b0 || bus.SAT !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state Q=%0d AT_MIN=%b AT_MAX=%b STEP=%b SAT=%b required Q=0 AT_MIN=1 AT_MAX=0 STEP=0 SAT=0",
                     bus.Q, bus.AT_MIN, bus.AT_MAX, bus.STEP, bus.SAT);
        end
        bus.BTN_UP = 1'b0;
        bus.BTN_DN = 1'b0;
        tick();
        N_RESET = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            tests_run++;
            if (bus.Q !== 4'd0 || bus.STEP !== 1'b0 || bus.SAT !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_idle k=%0d Q=%0d STEP=%b SAT=%b required Q=0 STEP=0 SAT=0",
                         k, bus.Q, bus.STEP, bus.SAT);
            end
        end
    endtask

    // Up press from 0 then down press from 1; Q moves at edge 7 only.
    task automatic test_single_press();
        logic [3:0] q_before, q_after, exp_q;
        logic       exp_step;
        for (int d = 0; d < 2; d++) begin
            q_before = (d == 0) ? 4'd0 : 4'd1;
            q_after  = (d == 0) ? 4'd1 : 4'd0;
            if (d == 0) bus.BTN_UP = 1'b1;
            else        bus.BTN_DN = 1'b1;
            for (int k = 1; k <= 20; k++) begin
                tick();
                if (k == 6) begin
                    bus.BTN_UP = 1'b0;
                    bus.BTN_DN = 1'b0;
                end
                exp_q    = (k >= 7) ? q_after : q_before;
                exp_step = (k == 7);
                tests_run++;
                if (bus.Q !== exp_q || bus.STEP !== exp_step || bus.SAT !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL single_press dir=%0d k=%0d Q=%0d STEP=%b SAT=%b required Q=%0d STEP=%b SAT=0",
                             d, k, bus.Q, bus.STEP, bus.SAT, exp_q, exp_step);
                end
            end
        end
    endtask

    task automatic test_bounce();
        int steps = 0;
        int sats  = 0;
        for (int p = 0; p < 5; p++) begin
            bus.BTN_UP = 1'b1;
            for (int c = 0; c < 3; c++) begin
                tick();
                steps += int'(bus.STEP);
                sats  += int'(bus.SAT);
            end
            bus.BTN_UP = 1'b0;
            for (int c = 0; c < 2; c++) begin
                tick();
                steps += int'(bus.STEP);
                sats  += int'(bus.SAT);
            end
        end
        tests_run++;
        if (steps != 0 || sats != 0 || bus.Q !== 4'd0) begin
            tests_failed++;
            $display("FAIL bounce_reject steps=%0d sats=%0d Q=%0d required steps=0 sats=0 Q=0",
                     steps, sats, bus.Q);
        end
        bus.BTN_UP = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (c == 9) bus.BTN_UP = 1'b0;
            steps += int'(bus.STEP);
            sats  += int'(bus.SAT);
        end
        tests_run++;
        if (steps != 1 || sats != 0 || bus.Q !== 4'd1) begin
            tests_failed++;
            $display("FAIL bounce_hold steps=%0d sats=%0d Q=%0d required steps=1 sats=0 Q=1",
                     steps, sats, bus.Q);
        end
    endtask

    // From Q=1, 90-cycle hold: initial step + 10 repeats (edges 7,23,31..95).
    task automatic test_repeat_climb();
        int steps = 0;
        bus.BTN_UP = 1'b1;
        for (int k = 1; k <= 110; k++) begin
            tick();
            if (k == 90) bus.BTN_UP = 1'b0;
            steps += int'(bus.STEP);
        end
        tests_run++;
        if (steps != 11 || bus.Q !== 4'd12) begin
            tests_failed++;
            $display("FAIL repeat_climb steps=%0d Q=%0d required steps=11 Q=12", steps, bus.Q);
        end
    endtask

    task automatic test_repeat_saturate();
        logic [3:0] exp_q;
        logic       exp_step, exp_sat;
        bus.BTN_UP = 1'b1;
        for (int k = 1; k <= 230; k++) begin
            tick();
            if (k == 200) bus.BTN_UP = 1'b0;
            exp_q    = (k >= 31) ? 4'd15 : (k >= 23) ? 4'd14 : (k >= 7) ? 4'd13 : 4'd12;
            exp_step = (k == 7) || (k == 23) || (k == 31);
            exp_sat  = (k >= 39) && (k <= 199) && (((k - 39) % 8) == 0);
            tests_run++;
            if (bus.Q !== exp_q || bus.STEP !== exp_step || bus.SAT !== exp_sat ||
                bus.AT_MAX !== (exp_q == 4'd15)) begin
                tests_failed++;
                $display("FAIL repeat_saturate k=%0d Q=%0d STEP=%b SAT=%b AT_MAX=%b required Q=%0d STEP=%b SAT=%b",
                         k, bus.Q, bus.STEP, bus.SAT, bus.AT_MAX, exp_q, exp_step, exp_sat);
            end
        end
    endtask

    // From 15, 68-cycle down hold: initial + 7 repeats -> 7; then both buttons.
    task automatic test_simultaneous();
        int steps = 0;
        bus.BTN_DN = 1'b1;
        for (int k = 1; k <= 90; k++) begin
            tick();
            if (k == 68) bus.BTN_DN = 1'b0;
            steps += int'(bus.STEP);
        end
        tests_run++;
        if (steps != 8 || bus.Q !== 4'd7) begin
            tests_failed++;
            $display("FAIL repeat_descend steps=%0d Q=%0d required steps=8 Q=7", steps, bus.Q);
        end
        bus.BTN_UP = 1'b1;
        bus.BTN_DN = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (k == 40) bus.BTN_DN = 1'b0;
            if (k == 80) bus.BTN_UP = 1'b0;
            tests_run++;
            if (bus.Q !== 4'd7 || bus.STEP !== 1'b0 || bus.SAT !== 1'b0) begin
                tests_failed++;
                $display("FAIL simultaneous k=%0d Q=%0d STEP=%b SAT=%b required Q=7 STEP=0 SAT=0",
                         k, bus.Q, bus.STEP, bus.SAT);
            end
        end
    endtask

    task automatic test_reset_mid_repeat();
        logic exp_sat;
        bus.BTN_UP = 1'b1;
        for (int k = 1; k <= 26; k++) tick();
        tests_run++;
        if (bus.Q !== 4'd9) begin
            tests_failed++;
            $display("FAIL mid_repeat_pre Q=%0d required Q=9", bus.Q);
        end
        N_RESET = 1'b0;
        #1;
        tests_run++;
        if (bus.Q !== 4'd0 || bus.AT_MIN !== 1'b1 || bus.STEP !== 1'b0 || bus.SAT !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset Q=%0d AT_MIN=%b STEP=%b SAT=%b required Q=0 AT_MIN=1 STEP=0 SAT=0",
                     bus.Q, bus.AT_MIN, bus.STEP, bus.SAT);
        end
        bus.BTN_UP = 1'b0;
        bus.BTN_DN = 1'b1;
        tick();
        tick();
        N_RESET = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (k == 10) bus.BTN_DN = 1'b0;
            exp_sat = (k == 7);
            tests_run++;
            if (bus.Q !== 4'd0 || bus.STEP !== 1'b0 || bus.SAT !== exp_sat) begin
                tests_failed++;
                $display("FAIL post_reset_press k=%0d Q=%0d STEP=%b SAT=%b required Q=0 STEP=0 SAT=%b",
                         k, bus.Q, bus.STEP, bus.SAT, exp_sat);
            end
        end
    endtask

    initial begin
        bus.BTN_UP = 1'b0;
        bus.BTN_DN = 1'b0;
        test_reset();
        test_single_press();
        test_bounce();
        test_repeat_climb();
        test_repeat_saturate();
        test_simultaneous();
        test_reset_mid_repeat();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

endmodule
